// File: rtl/colour_map_pipe.sv
// colour_map_pipe: phase/magnitude to RGB colour mapper.
//
// Maps a signed phase (hue) and an unsigned log-magnitude (brightness) per
// pixel onto an RGB triple. The pipeline has three stages, or four when the
// square-law gamma stage is built in.
//   S1  hue = phase + half-turn + hue_offset (mod 2^PHASE_W)
//   S2  hue -> six-sector colour wheel (or full white in grey mode)
//   Sg  (optional) mag' = mag^2 >> MAG_W
//   S3  channel * mag, keep the top COL_W bits (output registers)
//
// All stages advance together on en = !m_valid || m_ready. Bubbles are not
// collapsed, so a stalled output freezes the whole pipe and s_ready drops
// in the same cycle.
//
// Build option:
//   COLOUR_MAP_GAMMA_EN  define to insert the gamma stage (latency 4 instead of 3)
//
// Ports:
//   clk, resetn            clock; asynchronous active-low reset
//   s_valid/s_ready        input handshake
//   s_phase                signed phase, two's complement
//   s_mag                  unsigned log-magnitude
//   s_last                 line-end marker, travels with its pixel
//   hue_offset             hue rotation, sampled with each accepted pixel
//   gray_mode              grey output scaled by magnitude, sampled per pixel
//   m_valid/m_ready        output handshake
//   m_red/m_green/m_blue   output colour
//   m_last                 line-end marker aligned with the output pixel
module colour_map_pipe #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned MAG_W   = 8,
  parameter int unsigned COL_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PHASE_W-1:0] s_phase,
  input  logic [MAG_W-1:0]   s_mag,
  input  logic               s_last,
  input  logic [PHASE_W-1:0] hue_offset,
  input  logic               gray_mode,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COL_W-1:0]   m_red,
  output logic [COL_W-1:0]   m_green,
  output logic [COL_W-1:0]   m_blue,
  output logic               m_last
);

  localparam int unsigned ProdW = PHASE_W + MAG_W;
  localparam int unsigned PW    = PHASE_W + 3;

  // Adding a half turn moves the signed phase -2^(W-1) onto hue 0 (red).
  localparam logic [PHASE_W-1:0] HueBias = {1'b1, {(PHASE_W - 1){1'b0}}};
  localparam logic [PHASE_W-1:0] ChanMax = {PHASE_W{1'b1}};

  // Scale a full-precision channel by the brightness and keep the top COL_W bits.
  function automatic logic [COL_W-1:0] scale_chan(input logic [PHASE_W-1:0] chan,
                                                  input logic [MAG_W-1:0]   mag);
    logic [ProdW-1:0] prod;
    prod = {{MAG_W{1'b0}}, chan} * {{PHASE_W{1'b0}}, mag};
    return COL_W'(prod >> (ProdW - COL_W));
  endfunction

  // Global advance
  logic en;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  // Stage S1: hue rotation
  logic               s1_valid_q;
  logic [PHASE_W-1:0] s1_hue_q, s1_hue_d;
  logic [MAG_W-1:0]   s1_mag_q;
  logic               s1_last_q;
  logic               s1_gray_q;

  always_comb begin
    s1_hue_d = s_phase + HueBias + hue_offset;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_hue_q   <= '0;
      s1_mag_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_gray_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= s_valid;
      s1_hue_q   <= s1_hue_d;
      s1_mag_q   <= s_mag;
      s1_last_q  <= s_last;
      s1_gray_q  <= gray_mode;
    end
  end

  // Stage S2: colour wheel
  logic [PW-1:0]      hue_x6;
  logic [2:0]         sector;
  logic [PHASE_W-1:0] frac;
  logic [PHASE_W-1:0] s2_red_d, s2_green_d, s2_blue_d;

  logic               s2_valid_q;
  logic [PHASE_W-1:0] s2_red_q, s2_green_q, s2_blue_q;
  logic [MAG_W-1:0]   s2_mag_q;
  logic               s2_last_q;

  always_comb begin
    // hue * 6 as shift-and-add; the top three bits select the sector.
    hue_x6 = ({3'b000, s1_hue_q} << 2) + ({3'b000, s1_hue_q} << 1);
    sector = 3'(hue_x6 >> PHASE_W);
    frac   = hue_x6[PHASE_W-1:0];

    s2_red_d   = ChanMax;
    s2_green_d = '0;
    s2_blue_d  = '0;
    if (s1_gray_q) begin
      s2_red_d   = ChanMax;
      s2_green_d = ChanMax;
      s2_blue_d  = ChanMax;
    end else begin
      case (sector)
        3'd0: begin
          s2_red_d   = ChanMax;
          s2_green_d = frac;
          s2_blue_d  = '0;
        end
        3'd1: begin
          s2_red_d   = ChanMax - frac;
          s2_green_d = ChanMax;
          s2_blue_d  = '0;
        end
        3'd2: begin
          s2_red_d   = '0;
          s2_green_d = ChanMax;
          s2_blue_d  = frac;
        end
        3'd3: begin
          s2_red_d   = '0;
          s2_green_d = ChanMax - frac;
          s2_blue_d  = ChanMax;
        end
        3'd4: begin
          s2_red_d   = frac;
          s2_green_d = '0;
          s2_blue_d  = ChanMax;
        end
        // Sector 5; sectors 6 and 7 cannot occur but fall back to it.
        default: begin
          s2_red_d   = ChanMax;
          s2_green_d = '0;
          s2_blue_d  = ChanMax - frac;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_red_q   <= '0;
      s2_green_q <= '0;
      s2_blue_q  <= '0;
      s2_mag_q   <= '0;
      s2_last_q  <= 1'b0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_red_q   <= s2_red_d;
      s2_green_q <= s2_green_d;
      s2_blue_q  <= s2_blue_d;
      s2_mag_q   <= s1_mag_q;
      s2_last_q  <= s1_last_q;
    end
  end

  // Feed for the output stage: straight from S2, or via the gamma stage.
  logic               st_valid;
  logic [PHASE_W-1:0] st_red, st_green, st_blue;
  logic [MAG_W-1:0]   st_mag;
  logic               st_last;

`ifdef COLOUR_MAP_GAMMA_EN
  logic [2*MAG_W-1:0] mag_sq;
  logic [MAG_W-1:0]   sg_mag_d;

  logic               sg_valid_q;
  logic [PHASE_W-1:0] sg_red_q, sg_green_q, sg_blue_q;
  logic [MAG_W-1:0]   sg_mag_q;
  logic               sg_last_q;

  always_comb begin
    mag_sq   = {{MAG_W{1'b0}}, s2_mag_q} * {{MAG_W{1'b0}}, s2_mag_q};
    sg_mag_d = MAG_W'(mag_sq >> MAG_W);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sg_valid_q <= 1'b0;
      sg_red_q   <= '0;
      sg_green_q <= '0;
      sg_blue_q  <= '0;
      sg_mag_q   <= '0;
      sg_last_q  <= 1'b0;
    end else if (en) begin
      sg_valid_q <= s2_valid_q;
      sg_red_q   <= s2_red_q;
      sg_green_q <= s2_green_q;
      sg_blue_q  <= s2_blue_q;
      sg_mag_q   <= sg_mag_d;
      sg_last_q  <= s2_last_q;
    end
  end

  assign st_valid = sg_valid_q;
  assign st_red   = sg_red_q;
  assign st_green = sg_green_q;
  assign st_blue  = sg_blue_q;
  assign st_mag   = sg_mag_q;
  assign st_last  = sg_last_q;
`else
  assign st_valid = s2_valid_q;
  assign st_red   = s2_red_q;
  assign st_green = s2_green_q;
  assign st_blue  = s2_blue_q;
  assign st_mag   = s2_mag_q;
  assign st_last  = s2_last_q;
`endif

  // Stage S3: brightness scaling into the output registers
  logic [COL_W-1:0] red_d, green_d, blue_d;

  always_comb begin
    red_d   = scale_chan(st_red, st_mag);
    green_d = scale_chan(st_green, st_mag);
    blue_d  = scale_chan(st_blue, st_mag);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_red   <= '0;
      m_green <= '0;
      m_blue  <= '0;
      m_last  <= 1'b0;
    end else if (en) begin
      m_valid <= st_valid;
      m_red   <= red_d;
      m_green <= green_d;
      m_blue  <= blue_d;
      m_last  <= st_last;
    end
  end

endmodule

// File: tb/tb_colour_map_pipe.sv
// Bench for colour_map_pipe with default parameters (16/8/8).
module tb_colour_map_pipe;

`ifdef COLOUR_MAP_GAMMA_EN
  localparam bit GammaEn = 1'b1;
`else
  localparam bit GammaEn = 1'b0;
`endif
  localparam int Lat = GammaEn ? 4 : 3;
  localparam int NV  = 12;

  logic        clk;
  logic        resetn;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_phase;
  logic [7:0]  s_mag;
  logic        s_last;
  logic [15:0] hue_offset;
  logic        gray_mode;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_red;
  logic [7:0]  m_green;
  logic [7:0]  m_blue;
  logic        m_last;

  colour_map_pipe #(
    .PHASE_W(16),
    .MAG_W  (8),
    .COL_W  (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_phase   (s_phase),
    .s_mag     (s_mag),
    .s_last    (s_last),
    .hue_offset(hue_offset),
    .gray_mode (gray_mode),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_red     (m_red),
    .m_green   (m_green),
    .m_blue    (m_blue),
    .m_last    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       last;
  } exp_t;

  typedef struct {
    logic [15:0] phase;
    logic [7:0]  mag;
    logic [15:0] off;
    logic        gray;
    logic [23:0] lin;   // expected {r,g,b}, linear magnitude
    logic [23:0] gam;   // expected {r,g,b}, square-law magnitude
  } vec_t;

  vec_t        vt[NV];
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          prev_stall = 1'b0;
  logic [25:0] prev_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference mapping straight from the arithmetic definition.
  function automatic exp_t model(input logic [15:0] ph, input logic [7:0] mag,
                                 input logic [15:0] off, input logic gray,
                                 input logic last);
    longint hue, p, f, sec, m, rc, gc, bc;
    longint full;
    exp_t   e;
    full = 65535;
    hue  = (longint'($signed(ph)) + 32768 + longint'(off)) % 65536;
    p    = hue * 6;
    sec  = p / 65536;
    f    = p % 65536;
    case (sec)
      0: begin rc = full;     gc = f;        bc = 0;        end
      1: begin rc = full - f; gc = full;     bc = 0;        end
      2: begin rc = 0;        gc = full;     bc = f;        end
      3: begin rc = 0;        gc = full - f; bc = full;     end
      4: begin rc = f;        gc = 0;        bc = full;     end
      default: begin rc = full; gc = 0;      bc = full - f; end
    endcase
    if (gray) begin
      rc = full; gc = full; bc = full;
    end
    m = longint'(mag);
    if (GammaEn) m = (m * m) / 256;
    e.r    = 8'((rc * m) / 65536);
    e.g    = 8'((gc * m) / 65536);
    e.b    = 8'((bc * m) / 65536);
    e.last = last;
    return e;
  endfunction

  function automatic exp_t vexp(input int i, input logic last);
    logic [23:0] bits;
    exp_t        e;
    bits   = GammaEn ? vt[i].gam : vt[i].lin;
    e.r    = bits[23:16];
    e.g    = bits[15:8];
    e.b    = bits[7:0];
    e.last = last;
    return e;
  endfunction

  task automatic drive_vec(input int i, input logic last);
    s_valid    = 1'b1;
    s_phase    = vt[i].phase;
    s_mag      = vt[i].mag;
    hue_offset = vt[i].off;
    gray_mode  = vt[i].gray;
    s_last     = last;
  endtask

  // Called just after a falling edge with inputs driven: samples both
  // handshakes, runs the scoreboard, then waits for the next falling edge.
  task automatic step(input exp_t e, output bit acc, output bit outp);
    exp_t x;
    #1;
    acc  = s_valid && s_ready;
    outp = m_valid && m_ready;
    if (prev_stall)
      chk("hold_stable", {m_valid, m_last, m_red, m_green, m_blue}, prev_out);
    if (m_valid && !m_ready) chk("s_ready_low_in_stall", s_ready, 0);
    if (outp) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got rgb %0h/%0h/%0h, expected none",
                 m_red, m_green, m_blue);
      end else begin
        x = sb.pop_front();
        chk("pixel_rgb_last", {m_red, m_green, m_blue, m_last}, {x.r, x.g, x.b, x.last});
      end
    end
    if (acc) sb.push_back(e);
    prev_stall = m_valid && !m_ready;
    prev_out   = {m_valid, m_last, m_red, m_green, m_blue};
    @(negedge clk);
  endtask

  // One isolated pixel through an empty pipe, measuring latency.
  task automatic single_pixel(input string nm);
    bit   acc, outp;
    int   n;
    exp_t e;
    e = vexp(0, 1'b1);
    drive_vec(0, 1'b1);
    step(e, acc, outp);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk({nm, "_accept"}, acc, 1);
    n    = 0;
    outp = 1'b0;
    while (!outp && n < 12) begin
      n++;
      step(e, acc, outp);
    end
    chk({nm, "_latency"}, n, Lat);
  endtask

  initial begin
    bit   acc, outp;
    int   idx, budget, nout, k;
    exp_t e;

    // hue = phase + 0x8000 + offset; 0 = red, 0x8000 = cyan.
    vt[0]  = '{16'h8000, 8'd255, 16'h0000, 1'b0, 24'hFE0000, 24'hFD0000};
    vt[1]  = '{16'h0000, 8'd255, 16'h0000, 1'b0, 24'h00FEFE, 24'h00FDFD};
    vt[2]  = '{16'h0000, 8'd128, 16'h0000, 1'b0, 24'h007F7F, 24'h003F3F};
    vt[3]  = '{16'h8000, 8'd255, 16'h8000, 1'b0, 24'h00FEFE, 24'h00FDFD};
    vt[4]  = '{16'h7FFF, 8'd255, 16'h0001, 1'b0, 24'hFE0000, 24'hFD0000};
    vt[5]  = '{16'h04D2, 8'd128, 16'h0000, 1'b1, 24'h7F7F7F, 24'h3F3F3F};
    vt[6]  = '{16'h04D2, 8'd0,   16'h0000, 1'b1, 24'h000000, 24'h000000};
    vt[7]  = '{16'h1388, 8'd0,   16'h0000, 1'b0, 24'h000000, 24'h000000};
    vt[8]  = '{16'h9555, 8'd255, 16'h0000, 1'b0, 24'hFE7F00, 24'hFD7E00};
    vt[9]  = '{16'h2AAB, 8'd255, 16'h0000, 1'b0, 24'h0000FE, 24'h0000FD};
    vt[10] = '{16'h6A60, 8'd255, 16'h0000, 1'b0, 24'hFE0081, 24'hFD0080};
    vt[11] = '{16'hF530, 8'd255, 16'h0000, 1'b0, 24'h00FEBE, 24'h00FDBD};

    resetn     = 1'b0;
    s_valid    = 1'b0;
    s_phase    = '0;
    s_mag      = '0;
    s_last     = 1'b0;
    hue_offset = '0;
    gray_mode  = 1'b0;
    m_ready    = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {m_valid, m_last, m_red, m_green, m_blue}, 0);
    chk("reset_s_ready", s_ready, 1);
    resetn = 1'b1;
    @(negedge clk);

    // Vector table, back to back, last marker on the final entry.
    idx    = 0;
    budget = 0;
    while ((idx < NV || sb.size() > 0) && budget < 200) begin
      if (idx < NV) drive_vec(idx, idx == NV - 1);
      else s_valid = 1'b0;
      e = vexp(idx < NV ? idx : 0, idx == NV - 1);
      step(e, acc, outp);
      if (acc) idx++;
      budget++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("table_drained", budget < 200, 1);

    single_pixel("latency");

    // Backpressure: 10 pixels, increasing magnitude, 5-cycle stall mid-stream.
    idx    = 0;
    nout   = 0;
    k      = 0;
    while ((idx < 10 || sb.size() > 0) && k < 200) begin
      m_ready = !(k >= 5 && k < 10);
      if (idx < 10) begin
        s_valid    = 1'b1;
        s_phase    = 16'($urandom);
        s_mag      = 8'(25 * (idx + 1));
        hue_offset = 16'h1234;
        gray_mode  = (idx == 3);
        s_last     = (idx == 9);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      e = model(s_phase, s_mag, hue_offset, gray_mode, s_last);
      step(e, acc, outp);
      if (acc && idx < 10) idx++;
      if (outp) nout++;
      k++;
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    gray_mode = 1'b0;
    m_ready   = 1'b1;
    chk("bp_output_count", nout, 10);

    // Reset with three pixels held in flight.
    idx = 0;
    k   = 0;
    while (idx < 3 && k < 20) begin
      s_valid    = 1'b1;
      s_phase    = 16'h8000;
      s_mag      = 8'd200;
      hue_offset = '0;
      e = model(s_phase, s_mag, hue_offset, 1'b0, 1'b0);
      step(e, acc, outp);
      if (acc) idx++;
      k++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("pre_reset_valid", m_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_clears", {m_valid, m_last, m_red, m_green, m_blue}, 0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
    m_ready = 1'b1;
    nout    = 0;
    for (int i = 0; i < 8; i++) begin
      step(e, acc, outp);
      if (outp) nout++;
    end
    chk("no_stale_after_reset", nout, 0);

    single_pixel("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
